// File: rtl/gcc_stream_centroid_pkg.sv
// gcc_pkg: shared state encoding and width helpers for the stream centroid engine.
package gcc_pkg;
  typedef enum logic [2:0] {FILL, IDLE, SCAN, REPL, DIV} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int sum_w(input int n, input int cw, input int ww);
    return cw + ww + clog2(n);
  endfunction
  function automatic int sw_w(input int n, input int ww);
    return ww + clog2(n);
  endfunction
  function automatic int dist_w(input int cw);
    return 2 * cw + 1;
  endfunction
endpackage

// File: rtl/gcc_stream_centroid_div.sv
// gcc_seq_div: restoring divider producing a Q_W-bit quotient in Q_W cycles; zero divisor gives 0.
module gcc_seq_div
  import gcc_pkg::*;
#(
  parameter int NUM_W = 15,
  parameter int DEN_W = 7,
  parameter int Q_W   = 8
) (
  input  logic             CLK,
  input  logic             RESET_,
  input  logic             CLR,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quot
);
  localparam int C_W = clog2(Q_W + 1);
  logic [C_W-1:0]   r_cnt;
  logic [DEN_W-1:0] r_rem, r_den, w_sub;
  logic [Q_W-1:0]   r_sh, w_sh;
  logic [DEN_W:0]   w_cat;
  logic             w_ge;
  // The quotient is known to fit Q_W bits, so the bits above Q_W start out as a remainder below den.
  always_comb begin
    w_cat = {r_rem, r_sh[Q_W-1]};
    w_ge  = w_cat >= {1'b0, r_den};
    w_sub = w_cat[DEN_W-1:0] - r_den;
    w_sh  = {r_sh[Q_W-2:0], w_ge};
    busy  = r_cnt != '0;
    done  = r_cnt == C_W'(1);
    quot  = (r_den == '0) ? '0 : w_sh;
  end
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_den <= '0;
      r_sh  <= '0;
    end else if (CLR) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= C_W'(Q_W);
      r_rem <= DEN_W'(num >> Q_W);
      r_sh  <= num[Q_W-1:0];
      r_den <= den;
    end else if (busy) begin
      r_cnt <= r_cnt - 1'b1;
      r_rem <= w_ge ? w_sub : w_cat[DEN_W-1:0];
      r_sh  <= w_sh;
    end
  end
endmodule

// File: rtl/gcc_stream_centroid.sv
// gcc_stream_centroid: weighted centroid of an N-point window; once full, each new point
// replaces the stored point farthest from the current centroid.
module gcc_stream_centroid
  import gcc_pkg::*;
#(
  parameter int N  = 6,
  parameter int CW = 8,
  parameter int WW = 4
) (
  input  logic          CLK,
  input  logic          RESET_,
  input  logic          CLR,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [CW-1:0] Xi,
  input  logic [CW-1:0] Yi,
  input  logic [WW-1:0] Wi,
  output logic          READY_,
  output logic [CW-1:0] Xc,
  output logic [CW-1:0] Yc
);
  localparam int LN = clog2(N);
  localparam int SUM_W = sum_w(N, CW, WW);
  localparam int SW_W = sw_w(N, WW);
  localparam int D_W = dist_w(CW);
  localparam logic [LN-1:0] LAST = LN'(N - 1);
  state_t           r_state, w_next;
  logic [CW-1:0]    r_x [N];
  logic [CW-1:0]    r_y [N];
  logic [WW-1:0]    r_w [N];
  logic [LN-1:0]    r_cnt, r_idx, r_win;
  logic [SUM_W-1:0] r_sx, r_sy, w_tx, w_ty, w_ox, w_oy;
  logic [SW_W-1:0]  r_sw;
  logic [CW-1:0]    r_nx, r_ny, r_xc, r_yc, w_ax, w_ay, w_dx, w_dy, w_qx, w_qy;
  logic [WW-1:0]    r_nw, w_aw;
  logic [D_W-1:0]   r_wd, w_d;
  logic             w_acc, w_better, w_start, w_bx, w_by, w_dnx, w_dny;
  assign Xc = r_xc;
  assign Yc = r_yc;
  always_comb begin
    IN_READY = r_state == FILL || r_state == IDLE;
    READY_   = r_state != IDLE;
    w_acc    = IN_VALID && IN_READY;
    w_next   = r_state;
    unique case (r_state)
      FILL:    if (w_acc && r_cnt == LAST) w_next = DIV;
      IDLE:    if (w_acc) w_next = SCAN;
      SCAN:    if (r_idx == LAST) w_next = REPL;
      REPL:    w_next = DIV;
      DIV:     if (w_dnx && w_dny) w_next = IDLE;
      default: w_next = FILL;
    endcase
    if (CLR) w_next = FILL;
  end
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) r_state <= FILL;
    else r_state <= w_next;
  end
  // Incoming point terms come straight from the port while filling, from the latched point in REPL.
  always_comb begin
    w_ax  = (r_state == FILL) ? Xi : r_nx;
    w_ay  = (r_state == FILL) ? Yi : r_ny;
    w_aw  = (r_state == FILL) ? Wi : r_nw;
    w_tx  = SUM_W'(w_ax) * SUM_W'(w_aw);
    w_ty  = SUM_W'(w_ay) * SUM_W'(w_aw);
    w_ox  = SUM_W'(r_x[r_win]) * SUM_W'(r_w[r_win]);
    w_oy  = SUM_W'(r_y[r_win]) * SUM_W'(r_w[r_win]);
    w_dx  = (r_x[r_idx] > r_xc) ? r_x[r_idx] - r_xc : r_xc - r_x[r_idx];
    w_dy  = (r_y[r_idx] > r_yc) ? r_y[r_idx] - r_yc : r_yc - r_y[r_idx];
    w_d   = D_W'(w_dx) * D_W'(w_dx) + D_W'(w_dy) * D_W'(w_dy);
    w_better = r_idx == '0 || w_d > r_wd || (w_d == r_wd && (r_x[r_idx] < r_x[r_win] ||
               (r_x[r_idx] == r_x[r_win] && (r_y[r_idx] < r_y[r_win] ||
               (r_y[r_idx] == r_y[r_win] && r_w[r_idx] < r_w[r_win])))));
    w_start  = r_state == DIV && !(w_bx || w_by);
  end
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      for (int i = 0; i < N; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
        r_w[i] <= '0;
      end
      {r_cnt, r_idx, r_win, r_wd} <= '0;
      {r_sx, r_sy, r_sw} <= '0;
      {r_nx, r_ny, r_nw} <= '0;
      {r_xc, r_yc} <= '0;
    end else if (CLR) begin
      r_cnt <= '0;
      {r_sx, r_sy, r_sw} <= '0;
      {r_xc, r_yc} <= '0;
    end else begin
      if (r_state == FILL && w_acc) begin
        r_x[r_cnt] <= Xi;
        r_y[r_cnt] <= Yi;
        r_w[r_cnt] <= Wi;
        r_sx  <= r_sx + w_tx;
        r_sy  <= r_sy + w_ty;
        r_sw  <= r_sw + SW_W'(w_aw);
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == IDLE && w_acc) begin
        {r_nx, r_ny, r_nw} <= {Xi, Yi, Wi};
        r_idx <= '0;
      end
      if (r_state == SCAN) begin
        if (w_better) begin
          r_wd  <= w_d;
          r_win <= r_idx;
        end
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == REPL) begin
        r_sx <= r_sx - w_ox + w_tx;
        r_sy <= r_sy - w_oy + w_ty;
        r_sw <= r_sw - SW_W'(r_w[r_win]) + SW_W'(w_aw);
        r_x[r_win] <= r_nx;
        r_y[r_win] <= r_ny;
        r_w[r_win] <= r_nw;
      end
      if (r_state == DIV && w_dnx && w_dny) begin
        r_xc <= w_qx;
        r_yc <= w_qy;
      end
    end
  end
  gcc_seq_div #(.NUM_W(SUM_W), .DEN_W(SW_W), .Q_W(CW)) u_div_x (
    .CLK(CLK), .RESET_(RESET_), .CLR(CLR), .start(w_start),
    .num(r_sx + SUM_W'(r_sw >> 1)), .den(r_sw),
    .busy(w_bx), .done(w_dnx), .quot(w_qx)
  );
  gcc_seq_div #(.NUM_W(SUM_W), .DEN_W(SW_W), .Q_W(CW)) u_div_y (
    .CLK(CLK), .RESET_(RESET_), .CLR(CLR), .start(w_start),
    .num(r_sy + SUM_W'(r_sw >> 1)), .den(r_sw),
    .busy(w_by), .done(w_dny), .quot(w_qy)
  );
endmodule

// File: tb/tb_gcc_stream_centroid.sv
// tb_gcc_stream_centroid: scoreboard bench; a window model predicts each centroid when a point is accepted.
module tb_gcc_stream_centroid;
  localparam int N = 6, CW = 8, WW = 4;
  localparam int LAT_FILL = CW + 1, LAT_IDLE = N + CW + 2;
  logic CLK = 0, RESET_ = 0, CLR = 0, IN_VALID = 0;
  logic [CW-1:0] Xi = '0, Yi = '0, Xc, Yc;
  logic [WW-1:0] Wi = '0;
  logic IN_READY, READY_;
  int n_cmp = 0, n_bad = 0;
  int mx [N], my [N], mw [N];
  int mcnt = 0, mxc = 0, myc = 0;
  int qx [$], qy [$];
  int ex, ey, lat, wt, wsum;

  gcc_stream_centroid #(.N(N), .CW(CW), .WW(WW)) dut (
    .CLK(CLK), .RESET_(RESET_), .CLR(CLR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .Xi(Xi), .Yi(Yi), .Wi(Wi), .READY_(READY_), .Xc(Xc), .Yc(Yc)
  );
  always #5 CLK = ~CLK;

  function automatic void model_calc();
    int sx = 0, sy = 0, sw = 0;
    for (int i = 0; i < N; i++) begin
      sx += mx[i] * mw[i];
      sy += my[i] * mw[i];
      sw += mw[i];
    end
    mxc = (sw == 0) ? 0 : (sx + sw / 2) / sw;
    myc = (sw == 0) ? 0 : (sy + sw / 2) / sw;
    qx.push_back(mxc);
    qy.push_back(myc);
  endfunction

  function automatic void model_accept(int x, int y, int w);
    int win = 0, bd = -1, d;
    if (mcnt < N) begin
      mx[mcnt] = x; my[mcnt] = y; mw[mcnt] = w;
      mcnt++;
      if (mcnt == N) model_calc();
      return;
    end
    for (int i = 0; i < N; i++) begin
      d = (mx[i] - mxc) * (mx[i] - mxc) + (my[i] - myc) * (my[i] - myc);
      if (d > bd || (d == bd && (mx[i] < mx[win] || (mx[i] == mx[win] && (my[i] < my[win] ||
          (my[i] == my[win] && mw[i] < mw[win])))))) begin
        bd = d;
        win = i;
      end
    end
    mx[win] = x; my[win] = y; mw[win] = w;
    model_calc();
  endfunction

  function automatic void model_clear();
    mcnt = 0; mxc = 0; myc = 0;
    qx.delete();
    qy.delete();
  endfunction

  task automatic send(input int x, input int y, input int w, output int waits);
    waits = 0;
    @(negedge CLK);
    Xi = CW'(x); Yi = CW'(y); Wi = WW'(w); IN_VALID = 1;
    while (!IN_READY && waits < 200) begin
      waits++;
      @(negedge CLK);
    end
    if (!IN_READY) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: IN_READY=%0b after %0d cycles, required 1", IN_READY, waits);
      IN_VALID = 0;
      return;
    end
    @(posedge CLK);
    model_accept(x, y, w);
    #1 IN_VALID = 0;
  endtask

  task automatic wait_ready(output int l);
    l = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge CLK);
      #1;
      if (!READY_) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic do_clr();
    @(negedge CLK);
    CLR = 1;
    @(negedge CLK);
    CLR = 0;
    model_clear();
  endtask

  task automatic fill_same(input int x, input int y, input int w, output int ws);
    ws = 0;
    for (int i = 0; i < N; i++) begin
      send(x, y, w, wt);
      ws += wt;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    RESET_ = 1;
    #1;
    n_cmp++;
    if (Xc !== 0 || Yc !== 0) begin
      n_bad++; $display("FAIL reset_xy: Xc=%0d Yc=%0d, required 0 0", Xc, Yc);
    end
    n_cmp++;
    if (READY_ !== 1 || IN_READY !== 1) begin
      n_bad++; $display("FAIL reset_flags: READY_=%b IN_READY=%b, required 1 1", READY_, IN_READY);
    end
  endtask

  task automatic test_fill();
    fill_same(10, 10, 1, wsum);
    n_cmp++;
    if (wsum !== 0) begin
      n_bad++; $display("FAIL fill_in_ready: stall cycles %0d, required 0", wsum);
    end
    wait_ready(lat);
    ex = qx.pop_front(); ey = qy.pop_front();
    n_cmp++;
    if (lat !== LAT_FILL) begin
      n_bad++; $display("FAIL fill_latency: %0d, required %0d", lat, LAT_FILL);
    end
    n_cmp++;
    if (int'(Xc) !== ex || int'(Yc) !== ey || Xc !== 10 || Yc !== 10) begin
      n_bad++; $display("FAIL fill_result: %0d,%0d required %0d,%0d", Xc, Yc, ex, ey);
    end
  endtask

  task automatic test_rounding();
    for (int r = 0; r < 2; r++) begin
      do_clr();
      for (int i = 0; i < N; i++) send((i == N - 1) ? 3 - r : 0, 0, 1, wt);
      wait_ready(lat);
      ex = qx.pop_front(); ey = qy.pop_front();
      n_cmp++;
      if (lat !== LAT_FILL || int'(Xc) !== ex || int'(Yc) !== ey || int'(Xc) !== 1 - r) begin
        n_bad++; $display("FAIL round_%0d: lat %0d Xc %0d Yc %0d, required lat %0d Xc %0d Yc %0d",
                          r, lat, Xc, Yc, LAT_FILL, ex, ey);
      end
    end
  endtask

  task automatic test_replace();
    do_clr();
    for (int i = 0; i < N; i++) send((i == N - 1) ? 50 : 10, 10, 1, wt);
    wait_ready(lat);
    ex = qx.pop_front(); ey = qy.pop_front();
    n_cmp++;
    if (int'(Xc) !== ex || int'(Yc) !== ey || Xc !== 17 || Yc !== 10) begin
      n_bad++; $display("FAIL replace_fill: %0d,%0d required %0d,%0d", Xc, Yc, ex, ey);
    end
    send(10, 10, 1, wt);
    n_cmp++;
    if (READY_ !== 1 || Xc !== 17) begin
      n_bad++; $display("FAIL replace_hold: READY_=%b Xc=%0d, required 1 17", READY_, Xc);
    end
    wait_ready(lat);
    ex = qx.pop_front(); ey = qy.pop_front();
    n_cmp++;
    if (lat !== LAT_IDLE) begin
      n_bad++; $display("FAIL replace_latency: %0d, required %0d", lat, LAT_IDLE);
    end
    n_cmp++;
    if (int'(Xc) !== ex || int'(Yc) !== ey || Xc !== 10) begin
      n_bad++; $display("FAIL replace_result: %0d,%0d required %0d,%0d", Xc, Yc, ex, ey);
    end
  endtask

  task automatic test_tie();
    int px [N] = '{8, 12, 10, 10, 10, 10};
    int tail [3] = '{10, 10, 20};
    for (int k = 0; k < 3; k++) begin
      if (k != 1) begin
        do_clr();
        for (int i = 0; i < N; i++) send(px[i], 10, 1, wt);
        wait_ready(lat);
        ex = qx.pop_front(); ey = qy.pop_front();
        n_cmp++;
        if (int'(Xc) !== ex || int'(Yc) !== ey || Xc !== 10) begin
          n_bad++; $display("FAIL tie_fill_%0d: %0d,%0d required %0d,%0d", k, Xc, Yc, ex, ey);
        end
      end
      send(tail[k], 10, 1, wt);
      wait_ready(lat);
      ex = qx.pop_front(); ey = qy.pop_front();
      n_cmp++;
      if (lat !== LAT_IDLE || int'(Xc) !== ex || int'(Yc) !== ey) begin
        n_bad++; $display("FAIL tie_repl_%0d: lat %0d Xc %0d Yc %0d, required %0d %0d %0d",
                          k, lat, Xc, Yc, LAT_IDLE, ex, ey);
      end
    end
    n_cmp++;
    if (Xc !== 12) begin
      n_bad++; $display("FAIL tie_order: Xc=%0d, required 12", Xc);
    end
  endtask

  task automatic test_zero_backpressure();
    int pts [4][3] = '{'{100, 50, 2}, '{40, 40, 1}, '{200, 7, 15}, '{3, 250, 9}};
    do_clr();
    for (int i = 0; i < N; i++) send(i * 20, i * 10, 0, wt);
    wait_ready(lat);
    ex = qx.pop_front(); ey = qy.pop_front();
    n_cmp++;
    if (lat !== LAT_FILL || Xc !== 0 || Yc !== 0 || ex !== 0 || READY_ !== 0) begin
      n_bad++; $display("FAIL zero_weight: lat %0d Xc %0d Yc %0d READY_ %b, required %0d 0 0 0",
                        lat, Xc, Yc, READY_, LAT_FILL);
    end
    send(pts[0][0], pts[0][1], pts[0][2], wt);
    wait_ready(lat);
    ex = qx.pop_front(); ey = qy.pop_front();
    n_cmp++;
    if (int'(Xc) !== ex || int'(Yc) !== ey) begin
      n_bad++; $display("FAIL bp_first: %0d,%0d required %0d,%0d", Xc, Yc, ex, ey);
    end
    for (int k = 1; k < 4; k++) begin
      send(pts[k][0], pts[k][1], pts[k][2], wt);
      n_cmp++;
      if (wt !== ((k == 1) ? 0 : LAT_IDLE)) begin
        n_bad++; $display("FAIL bp_stall_%0d: %0d cycles, required %0d", k, wt, (k == 1) ? 0 : LAT_IDLE);
      end
      if (k > 1) begin
        ex = qx.pop_front(); ey = qy.pop_front();
        n_cmp++;
        if (int'(Xc) !== ex || int'(Yc) !== ey) begin
          n_bad++; $display("FAIL bp_result_%0d: %0d,%0d required %0d,%0d", k - 1, Xc, Yc, ex, ey);
        end
      end
    end
    wait_ready(lat);
    ex = qx.pop_front(); ey = qy.pop_front();
    n_cmp++;
    if (lat !== LAT_IDLE || int'(Xc) !== ex || int'(Yc) !== ey) begin
      n_bad++; $display("FAIL bp_last: lat %0d Xc %0d Yc %0d, required %0d %0d %0d",
                        lat, Xc, Yc, LAT_IDLE, ex, ey);
    end
  endtask

  task automatic test_abort();
    do_clr();
    fill_same(30, 40, 3, wsum);
    repeat (3) @(posedge CLK);
    #2 RESET_ = 0;
    #1;
    n_cmp++;
    if (Xc !== 0 || Yc !== 0 || READY_ !== 1 || IN_READY !== 1) begin
      n_bad++; $display("FAIL abort_reset: Xc %0d Yc %0d READY_ %b IN_READY %b, required 0 0 1 1",
                        Xc, Yc, READY_, IN_READY);
    end
    model_clear();
    @(negedge CLK);
    RESET_ = 1;
    fill_same(10, 10, 1, wsum);
    wait_ready(lat);
    ex = qx.pop_front(); ey = qy.pop_front();
    n_cmp++;
    if (lat !== LAT_FILL || Xc !== 10 || Yc !== 10 || int'(Xc) !== ex) begin
      n_bad++; $display("FAIL abort_refill_a: lat %0d Xc %0d Yc %0d, required %0d 10 10", lat, Xc, Yc, LAT_FILL);
    end
    send(50, 10, 1, wt);
    repeat (2) @(negedge CLK);
    CLR = 1;
    @(negedge CLK);
    CLR = 0;
    n_cmp++;
    if (Xc !== 0 || Yc !== 0 || READY_ !== 1 || IN_READY !== 1) begin
      n_bad++; $display("FAIL abort_clr: Xc %0d Yc %0d READY_ %b IN_READY %b, required 0 0 1 1",
                        Xc, Yc, READY_, IN_READY);
    end
    model_clear();
    fill_same(10, 10, 1, wsum);
    wait_ready(lat);
    ex = qx.pop_front(); ey = qy.pop_front();
    n_cmp++;
    if (lat !== LAT_FILL || Xc !== 10 || Yc !== 10 || int'(Yc) !== ey) begin
      n_bad++; $display("FAIL abort_refill_b: lat %0d Xc %0d Yc %0d, required %0d 10 10", lat, Xc, Yc, LAT_FILL);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_rounding();
    test_replace();
    test_tie();
    test_zero_backpressure();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
